// File: rtl/sub_bytes_sched_if.sv
// ----------------------------------------------------------------------------
// sub_bytes_sched_if
//   Request/response bundle between the round controller / key schedule
//   (master) and the shared SubBytes sequencer (slave).
//
//   st_req_valid / st_req_ready : state request handshake
//   st_in, st_inv               : 128-bit state (byte 0 in the MSBs), inverse flag
//   st_out_valid, st_out        : one-cycle completion pulse, held result
//   kw_req_valid / kw_req_ready : key-word request handshake
//   kw_in                       : 32-bit word (byte 0 in the MSBs)
//   kw_out_valid, kw_out        : one-cycle completion pulse, held SubWord result
// ----------------------------------------------------------------------------
interface sub_bytes_sched_if;
  logic         st_req_valid;
  logic         st_req_ready;
  logic [127:0] st_in;
  logic         st_inv;
  logic         st_out_valid;
  logic [127:0] st_out;
  logic         kw_req_valid;
  logic         kw_req_ready;
  logic [31:0]  kw_in;
  logic         kw_out_valid;
  logic [31:0]  kw_out;

  modport master (
    output st_req_valid, st_in, st_inv, kw_req_valid, kw_in,
    input  st_req_ready, st_out_valid, st_out, kw_req_ready, kw_out_valid, kw_out
  );

  modport slave (
    input  st_req_valid, st_in, st_inv, kw_req_valid, kw_in,
    output st_req_ready, st_out_valid, st_out, kw_req_ready, kw_out_valid, kw_out
  );
endinterface

// File: rtl/sub_bytes_sched.sv
// ----------------------------------------------------------------------------
// sub_bytes
//   Single-byte SubBytes lane: FIPS-197 forward S-box or its inverse.
//   din    : input byte
//   inv_en : 1 = inverse S-box, 0 = forward S-box
//   dout   : substituted byte (combinational)
// ----------------------------------------------------------------------------
module sub_bytes (
  input  logic [7:0] din,
  input  logic       inv_en,
  output logic [7:0] dout
);
  // Entry 0 sits in the most significant byte of each table.
  localparam logic [2047:0] FWD_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] INV_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  // Entry x occupies bits [2047-8x -: 8]; {~x, 3'b111} equals 2047-8x.
  function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
    sbox_fwd = FWD_TBL[{~x, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] x);
    sbox_inv = INV_TBL[{~x, 3'b111} -: 8];
  endfunction

  // Lane output select between forward and inverse table.
  always_comb begin
    dout = 8'h00;
    if (inv_en) begin
      dout = sbox_inv(din);
    end else begin
      dout = sbox_fwd(din);
    end
  end
endmodule

// ----------------------------------------------------------------------------
// sub_bytes_sched
//   Shares LANES SubBytes lanes between a 128-bit state requester (forward or
//   inverse) and a 32-bit key-word requester (forward only). Requests are taken
//   over valid/ready, processed LANES bytes per cycle, and returned in held
//   output registers with a one-cycle valid pulse.
//
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : sub_bytes_sched_if.slave (both request/response channels)
//
//   LANES : 1, 2, 4, 8 or 16
// ----------------------------------------------------------------------------
module sub_bytes_sched #(
  parameter int LANES = 4
) (
  input logic              clk,
  input logic              rst,
  sub_bytes_sched_if.slave bus
);
  if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
    $error("sub_bytes_sched: LANES must be 1, 2, 4, 8 or 16");
  end

  localparam int         P_ST    = 16 / LANES;
  localparam int         P_KW    = (LANES >= 4) ? 1 : (4 / LANES);
  localparam logic [3:0] LAST_ST = 4'(P_ST - 1);
  localparam logic [3:0] LAST_KW = 4'(P_KW - 1);
  localparam int         LSH     = $clog2(LANES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ST_RUN = 2'd1,
    KW_RUN = 2'd2
  } state_t;

  state_t           state_r;
  logic [3:0]       pcnt_r;
  logic             last_kw_r;
  logic             mode_r;
  logic [0:15][7:0] opnd_r;
  logic [0:15][7:0] res_r;
  logic [0:15][7:0] res_next_s;
  logic [127:0]     st_out_r;
  logic [31:0]      kw_out_r;
  logic             st_out_valid_r;
  logic             kw_out_valid_r;

  logic                       idle_s;
  logic                       grant_st_s;
  logic                       grant_kw_s;
  logic                       st_ready_s;
  logic                       kw_ready_s;
  logic                       st_acc_s;
  logic                       kw_acc_s;
  logic                       last_pass_s;
  logic [3:0]                 base_s;
  logic [LANES-1:0]           lane_wr_s;
  logic [LANES-1:0][3:0]      lane_idx_s;
  logic [LANES-1:0][7:0]      lane_in_s;
  logic [LANES-1:0][7:0]      lane_out_s;

  assign idle_s = (state_r == IDLE);

  // Round-robin grant: on a conflict the side not served last wins.
  assign grant_kw_s = bus.kw_req_valid && (!bus.st_req_valid || !last_kw_r);
  assign grant_st_s = bus.st_req_valid && (!bus.kw_req_valid || last_kw_r);

  // With nothing pending both sides are offered ready.
  assign st_ready_s = idle_s && (grant_st_s || (!bus.st_req_valid && !bus.kw_req_valid));
  assign kw_ready_s = idle_s && (grant_kw_s || (!bus.st_req_valid && !bus.kw_req_valid));

  assign st_acc_s = bus.st_req_valid && st_ready_s;
  assign kw_acc_s = bus.kw_req_valid && kw_ready_s;

  assign last_pass_s = ((state_r == ST_RUN) && (pcnt_r == LAST_ST)) ||
                       ((state_r == KW_RUN) && (pcnt_r == LAST_KW));

  // First operand byte of the current pass; truncation to 4 bits is intended.
  assign base_s = pcnt_r << LSH;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    // Lanes beyond the 4 key-word bytes idle on 8'h00 during KW_RUN.
    assign lane_wr_s[l]  = (state_r == ST_RUN) || ((state_r == KW_RUN) && (l < 4));
    assign lane_idx_s[l] = base_s + 4'(l);
    assign lane_in_s[l]  = lane_wr_s[l] ? opnd_r[lane_idx_s[l]] : 8'h00;

    sub_bytes u_sbox (
      .din    (lane_in_s[l]),
      .inv_en (mode_r),
      .dout   (lane_out_s[l])
    );
  end

  // Merge this pass's lane outputs into the result bytes they belong to.
  always_comb begin
    res_next_s = res_r;
    for (int l = 0; l < LANES; l++) begin
      if (lane_wr_s[l]) begin
        res_next_s[lane_idx_s[l]] = lane_out_s[l];
      end else begin
        res_next_s[lane_idx_s[l]] = res_r[lane_idx_s[l]];
      end
    end
  end

  // Sequencer FSM: accept, run the passes, commit the result with a pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= IDLE;
      pcnt_r         <= 4'd0;
      last_kw_r      <= 1'b0;
      mode_r         <= 1'b0;
      opnd_r         <= 128'h0;
      res_r          <= 128'h0;
      st_out_r       <= 128'h0;
      kw_out_r       <= 32'h0;
      st_out_valid_r <= 1'b0;
      kw_out_valid_r <= 1'b0;
    end else begin
      st_out_valid_r <= 1'b0;
      kw_out_valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          pcnt_r <= 4'd0;
          if (st_acc_s) begin
            opnd_r    <= bus.st_in;
            mode_r    <= bus.st_inv;
            last_kw_r <= 1'b0;
            state_r   <= ST_RUN;
          end else if (kw_acc_s) begin
            // Key word occupies bytes 0..3; the rest stays zero.
            opnd_r    <= {bus.kw_in, 96'h0};
            mode_r    <= 1'b0;
            last_kw_r <= 1'b1;
            state_r   <= KW_RUN;
          end else begin
            state_r <= IDLE;
          end
        end
        ST_RUN, KW_RUN: begin
          res_r <= res_next_s;
          if (last_pass_s) begin
            state_r <= IDLE;
            pcnt_r  <= 4'd0;
            if (state_r == ST_RUN) begin
              st_out_r       <= res_next_s;
              st_out_valid_r <= 1'b1;
            end else begin
              kw_out_r       <= res_next_s[0:3];
              kw_out_valid_r <= 1'b1;
            end
          end else begin
            pcnt_r <= pcnt_r + 4'd1;
          end
        end
        default: begin
          state_r <= IDLE;
          pcnt_r  <= 4'd0;
        end
      endcase
    end
  end

  assign bus.st_req_ready = st_ready_s;
  assign bus.kw_req_ready = kw_ready_s;
  assign bus.st_out       = st_out_r;
  assign bus.st_out_valid = st_out_valid_r;
  assign bus.kw_out       = kw_out_r;
  assign bus.kw_out_valid = kw_out_valid_r;
endmodule

// File: tb/tb_sub_bytes_sched.sv
// ----------------------------------------------------------------------------
// tb_sub_bytes_sched
//   Directed self-checking bench for sub_bytes_sched with LANES = 4, using
//   FIPS-197 S-box vectors computed by hand.
// ----------------------------------------------------------------------------
module tb_sub_bytes_sched;
  localparam int LANES = 4;

  localparam logic [127:0] FWD_IN  = 128'h00102030405060708090a0b0c0d0e0f0;
  localparam logic [127:0] FWD_OUT = 128'h63cab7040953d051cd60e0e7ba70e18c;
  localparam logic [31:0]  KW_IN   = 32'hcf4f3c09;
  localparam logic [31:0]  KW_OUT  = 32'h8a84eb01;

  logic clk;
  logic rst;
  sub_bytes_sched_if bus ();

  int total;
  int bad;
  int st_pulses;
  int kw_pulses;
  int both_valid_cnt;
  int both_ready_cnt;
  bit log_grants;
  logic grant_q[$];

  sub_bytes_sched #(.LANES(LANES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Event monitor, sampled on the falling edge away from the active edge.
  always @(negedge clk) begin
    if (bus.st_out_valid) st_pulses++;
    if (bus.kw_out_valid) kw_pulses++;
    if (bus.st_out_valid && bus.kw_out_valid) both_valid_cnt++;
    if (!rst && bus.st_req_valid && bus.kw_req_valid && bus.st_req_ready && bus.kw_req_ready)
      both_ready_cnt++;
    if (!rst && log_grants && bus.kw_req_valid && bus.kw_req_ready) grant_q.push_back(1'b1);
    if (!rst && log_grants && bus.st_req_valid && bus.st_req_ready) grant_q.push_back(1'b0);
  end

  // Issue one request, then check accept, latency, result and pulse shape.
  // Called at 1 time unit after a rising edge.
  task automatic run_req(input string tag, input bit is_kw, input logic [127:0] din,
                         input logic inv, input logic [127:0] exp, input int exp_lat);
    int n;
    bit acc;
    int sp0;
    int kp0;
    sp0 = st_pulses;
    kp0 = kw_pulses;
    if (is_kw) begin
      bus.kw_in        = din[31:0];
      bus.kw_req_valid = 1'b1;
    end else begin
      bus.st_in        = din;
      bus.st_inv       = inv;
      bus.st_req_valid = 1'b1;
    end
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 20) begin
      #1;
      acc = is_kw ? bus.kw_req_ready : bus.st_req_ready;
      @(posedge clk);
      #1;
      n++;
    end
    // Inputs are scrambled right after accept; the result must not change.
    bus.st_req_valid = 1'b0;
    bus.kw_req_valid = 1'b0;
    bus.st_in        = ~din;
    bus.st_inv       = ~inv;
    bus.kw_in        = ~din[31:0];
    chk({tag, "/accept"}, 128'(acc), 128'(1));
    n = 0;
    while (!(is_kw ? bus.kw_out_valid : bus.st_out_valid) && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "/latency"}, 128'(n), 128'(exp_lat));
    chk({tag, "/result"}, is_kw ? {96'h0, bus.kw_out} : bus.st_out, exp);
    @(posedge clk);
    #1;
    chk({tag, "/pulse_width"}, 128'(is_kw ? bus.kw_out_valid : bus.st_out_valid), 128'(0));
    chk({tag, "/own_pulses"}, 128'(is_kw ? kw_pulses - kp0 : st_pulses - sp0), 128'(1));
    chk({tag, "/other_pulses"}, 128'(is_kw ? st_pulses - sp0 : kw_pulses - kp0), 128'(0));
  endtask

  initial begin
    int n;
    int sp0;
    int kp0;
    int br0;
    total            = 0;
    bad              = 0;
    st_pulses        = 0;
    kw_pulses        = 0;
    both_valid_cnt   = 0;
    both_ready_cnt   = 0;
    log_grants       = 1'b0;
    rst              = 1'b1;
    bus.st_req_valid = 1'b0;
    bus.st_in        = 128'h0;
    bus.st_inv       = 1'b0;
    bus.kw_req_valid = 1'b0;
    bus.kw_in        = 32'h0;

    // Reset values.
    #2;
    chk("rst/st_out", bus.st_out, 128'h0);
    chk("rst/kw_out", {96'h0, bus.kw_out}, 128'h0);
    chk("rst/st_out_valid", 128'(bus.st_out_valid), 128'(0));
    chk("rst/kw_out_valid", 128'(bus.kw_out_valid), 128'(0));
    chk("rst/st_ready", 128'(bus.st_req_ready), 128'(1));
    chk("rst/kw_ready", 128'(bus.kw_req_ready), 128'(1));

    // Toggle valids while reset is held over 3 edges.
    for (int i = 0; i < 3; i++) begin
      bus.st_in        = FWD_IN;
      bus.kw_in        = KW_IN;
      bus.st_req_valid = i[0];
      bus.kw_req_valid = ~i[0];
      @(posedge clk);
      #1;
    end
    bus.st_req_valid = 1'b0;
    bus.kw_req_valid = 1'b0;
    rst              = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hold/st_ready", 128'(bus.st_req_ready), 128'(1));
    chk("rst_hold/kw_ready", 128'(bus.kw_req_ready), 128'(1));
    chk("rst_hold/pulses", 128'(st_pulses + kw_pulses), 128'(0));
    chk("rst_hold/st_out", bus.st_out, 128'h0);

    // Single requesters.
    run_req("fwd", 1'b0, FWD_IN, 1'b0, FWD_OUT, 4);
    run_req("inv", 1'b0, FWD_OUT, 1'b1, FWD_IN, 4);
    run_req("kw", 1'b1, {96'h0, KW_IN}, 1'b0, {96'h0, KW_OUT}, 1);

    // Contention: both valids held high from reset.
    rst              = 1'b1;
    bus.st_in        = FWD_IN;
    bus.st_inv       = 1'b0;
    bus.kw_in        = KW_IN;
    bus.st_req_valid = 1'b1;
    bus.kw_req_valid = 1'b1;
    log_grants       = 1'b1;
    grant_q.delete();
    @(posedge clk);
    #1;
    chk("cont/st_out_after_rst", bus.st_out, 128'h0);
    chk("cont/kw_out_after_rst", {96'h0, bus.kw_out}, 128'h0);
    rst = 1'b0;
    sp0 = st_pulses;
    kp0 = kw_pulses;
    br0 = both_ready_cnt;
    n   = 0;
    while (grant_q.size() < 4 && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    bus.st_req_valid = 1'b0;
    bus.kw_req_valid = 1'b0;
    log_grants       = 1'b0;
    chk("cont/grant_count", 128'(grant_q.size()), 128'(4));
    for (int i = 0; i < 4; i++) begin
      if (i < grant_q.size()) begin
        chk($sformatf("cont/grant%0d_is_key", i), 128'(grant_q[i]), 128'((i % 2) == 0));
      end
    end
    repeat (8) @(posedge clk);
    #1;
    chk("cont/st_out", bus.st_out, FWD_OUT);
    chk("cont/kw_out", {96'h0, bus.kw_out}, {96'h0, KW_OUT});
    chk("cont/st_pulses", 128'(st_pulses - sp0), 128'(2));
    chk("cont/kw_pulses", 128'(kw_pulses - kp0), 128'(2));
    chk("cont/both_ready", 128'(both_ready_cnt - br0), 128'(0));
    chk("cont/both_out_valid", 128'(both_valid_cnt), 128'(0));

    // Reset during pass 2 of a state operation.
    bus.st_in        = FWD_IN;
    bus.st_inv       = 1'b0;
    bus.st_req_valid = 1'b1;
    #1;
    chk("midrst/ready", 128'(bus.st_req_ready), 128'(1));
    @(posedge clk);
    #1;
    bus.st_req_valid = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    sp0 = st_pulses;
    rst = 1'b1;
    #1;
    chk("midrst/st_out_async", bus.st_out, 128'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("midrst/st_out", bus.st_out, 128'h0);
    chk("midrst/no_pulse", 128'(st_pulses - sp0), 128'(0));
    chk("midrst/idle_ready", 128'(bus.st_req_ready), 128'(1));
    run_req("reissue", 1'b0, FWD_IN, 1'b0, FWD_OUT, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
